// File: rtl/alarm_zone_if.sv
// Panel-side signal bundle between the zone controller and the sensor/LED board.
// The panel drives the raw inputs; the controller drives the registered indications.
interface alarm_zone_if;
  logic [5:0] sensor_in;
  logic       arm_sw;
  logic       ack_btn;
  logic       mtne_key;
  logic [5:0] led_enable;
  logic       mtne_mode;
  logic       alarm_active;
  logic [2:0] first_zone;
  logic [7:0] alarm_count;

  modport master (
    output sensor_in, arm_sw, ack_btn, mtne_key,
    input  led_enable, mtne_mode, alarm_active, first_zone, alarm_count
  );

  modport slave (
    input  sensor_in, arm_sw, ack_btn, mtne_key,
    output led_enable, mtne_mode, alarm_active, first_zone, alarm_count
  );
endinterface

// File: rtl/alarm_zone_controller.sv
// Six-zone alarm controller: synchronizes and debounces the panel inputs, then runs
// the DISARMED/ARMED/ALARM/MAINT state machine with fully registered indications.
module alarm_zone_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MTNE_HOLD       = 100000000
) (
  input logic         clock,
  input logic         reset,
  alarm_zone_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(MTNE_HOLD + 1);

  typedef enum logic [1:0] {DISARMED, ARMED, ALARM, MAINT} state_t;

  logic [8:0]    raw;
  logic [8:0]    sync1;
  logic [8:0]    sync2;
  logic [8:0]    deb;
  logic [CW-1:0] db_cnt [9];
  logic          ack_q;

  state_t        state;
  state_t        state_next;
  logic [5:0]    zone_latch;
  logic [5:0]    latch_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [2:0]    first_q;
  logic [2:0]    first_next;
  logic [7:0]    count_q;
  logic [7:0]    count_next;
  logic [5:0]    led_q;
  logic [5:0]    led_next;
  logic          mtne_q;
  logic          active_q;

  logic [5:0]    sens;
  logic          arm;
  logic          key;
  logic          ack_evt;

  // Bit order: sensors in [5:0], then arm, ack, maintenance key.
  assign raw     = {bus.mtne_key, bus.ack_btn, bus.arm_sw, bus.sensor_in};
  assign sens    = deb[5:0];
  assign arm     = deb[6];
  assign key     = deb[8];
  assign ack_evt = deb[7] & ~ack_q;

  function automatic logic [2:0] lowest(input logic [5:0] v);
    lowest = 3'd7;
    for (int i = 5; i >= 0; i--)
      if (v[i]) lowest = 3'(i);
  endfunction

  // Each input flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      ack_q <= 1'b0;
      for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      ack_q <= deb[7];
      for (int i = 0; i < 9; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    latch_next = zone_latch;
    first_next = first_q;
    count_next = count_q;
    hold_next  = '0;
    led_next   = '0;
    case (state)
      DISARMED: begin
        latch_next = '0;
        if (key && !arm) hold_next = hold_cnt + 1'b1;
        // Arming wins over a hold count completing in the same cycle.
        if (arm) begin
          state_next = ARMED;
        end else if (hold_next == HW'(MTNE_HOLD)) begin
          state_next = MAINT;
          hold_next  = '0;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_next = DISARMED;
        end else if (sens != 6'd0) begin
          state_next = ALARM;
          latch_next = sens;
          first_next = lowest(sens);
          if (count_q != 8'hFF) count_next = count_q + 8'd1;
        end
      end
      ALARM: begin
        if (!arm) begin
          state_next = DISARMED;
          latch_next = '0;
          first_next = 3'd7;
        end else if (ack_evt) begin
          latch_next = sens;
          if (sens == 6'd0) begin
            state_next = ARMED;
            first_next = 3'd7;
          end
        end else begin
          latch_next = zone_latch | sens;
        end
      end
      MAINT: begin
        if (!key) state_next = DISARMED;
      end
      default: state_next = DISARMED;
    endcase

    case (state_next)
      ALARM:   led_next = latch_next;
      MAINT:   led_next = sens;
      default: led_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= DISARMED;
      zone_latch <= '0;
      hold_cnt   <= '0;
      first_q    <= 3'd7;
      count_q    <= '0;
      led_q      <= '0;
      mtne_q     <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state      <= state_next;
      zone_latch <= latch_next;
      hold_cnt   <= hold_next;
      first_q    <= first_next;
      count_q    <= count_next;
      led_q      <= led_next;
      mtne_q     <= (state_next == MAINT);
      active_q   <= (state_next == ALARM);
    end
  end

  assign bus.led_enable   = led_q;
  assign bus.mtne_mode    = mtne_q;
  assign bus.alarm_active = active_q;
  assign bus.first_zone   = first_q;
  assign bus.alarm_count  = count_q;
endmodule

// File: tb/tb_alarm_zone_controller.sv
// Directed bench for alarm_zone_controller: a behavioural model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_alarm_zone_controller;
  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clock;
  logic reset;
  alarm_zone_if bus ();

  alarm_zone_controller #(.DEBOUNCE_CYCLES(DEB), .MTNE_HOLD(HOLD)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: inputs reach the debouncer two edges late; a level is accepted once it
  // has been seen DEB times in a row; the FSM follows the zone rules on those levels.
  bit         model_valid = 0;
  bit   [8:0] pipe1, pipe2, lvl;
  int         run [9];
  bit         ack_prev;
  int         m_state;   // 0 disarmed, 1 armed, 2 alarm, 3 maintenance
  bit   [5:0] m_latch;
  int         m_hold;
  bit   [5:0] e_led;
  bit         e_mtne, e_active;
  int         e_first, e_count;

  function automatic int first_set(input bit [5:0] v);
    int k = 0;
    while (k < 6 && !v[k]) k++;
    return (k == 6) ? 7 : k;
  endfunction

  always @(posedge clock) begin
    bit [8:0] raw_now;
    bit [5:0] s;
    bit a, k, evt;
    raw_now = {bus.mtne_key, bus.ack_btn, bus.arm_sw, bus.sensor_in};
    if (!reset) begin
      pipe1 = 0; pipe2 = 0; lvl = 0; ack_prev = 0;
      for (int i = 0; i < 9; i++) run[i] = 0;
      m_state = 0; m_latch = 0; m_hold = 0;
      e_first = 7; e_count = 0;
      model_valid = 1;
    end else begin
      s = lvl[5:0]; a = lvl[6]; k = lvl[8];
      evt = lvl[7] && !ack_prev;
      if (m_state == 0 && k && !a) m_hold = m_hold + 1;
      else m_hold = 0;
      case (m_state)
        0: begin
          m_latch = 0;
          if (a) m_state = 1;
          else if (m_hold >= HOLD) begin m_state = 3; m_hold = 0; end
        end
        1: begin
          if (!a) m_state = 0;
          else if (s != 0) begin
            m_state = 2; m_latch = s; e_first = first_set(s);
            e_count = (e_count >= 255) ? 255 : e_count + 1;
          end
        end
        2: begin
          if (!a) begin m_state = 0; m_latch = 0; e_first = 7; end
          else if (evt) begin
            m_latch = s;
            if (s == 0) begin m_state = 1; e_first = 7; end
          end else m_latch = m_latch | s;
        end
        default: if (!k) m_state = 0;
      endcase
      e_led = (m_state == 2) ? m_latch : (m_state == 3) ? s : 6'd0;
      ack_prev = lvl[7];
      for (int i = 0; i < 9; i++) begin
        if (pipe2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] >= DEB) begin lvl[i] = pipe2[i]; run[i] = 0; end
        end else run[i] = 0;
      end
      pipe2 = pipe1;
      pipe1 = raw_now;
    end
    if (!reset) e_led = 0;
    e_mtne   = (m_state == 3);
    e_active = (m_state == 2);
  end

  always @(negedge clock) begin
    if (model_valid) begin
      check_output("model_led",    int'(bus.led_enable),   int'(e_led));
      check_output("model_mtne",   int'(bus.mtne_mode),    int'(e_mtne));
      check_output("model_active", int'(bus.alarm_active), int'(e_active));
      check_output("model_first",  int'(bus.first_zone),   e_first);
      check_output("model_count",  int'(bus.alarm_count),  e_count);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input bit [5:0] s, input bit a, input bit k, input bit m);
    bus.sensor_in = s;
    bus.arm_sw    = a;
    bus.ack_btn   = k;
    bus.mtne_key  = m;
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(6'd0, 0, 0, 0);
    step(3);
    check_output("rst_led",    int'(bus.led_enable),   0);
    check_output("rst_mtne",   int'(bus.mtne_mode),    0);
    check_output("rst_active", int'(bus.alarm_active), 0);
    check_output("rst_first",  int'(bus.first_zone),   7);
    check_output("rst_count",  int'(bus.alarm_count),  0);
    reset = 1'b1;

    // Arm, then a 3-cycle glitch on zone 2 must be rejected.
    apply_stimulus(6'd0, 1, 0, 0);
    step(8);
    apply_stimulus(6'b000100, 1, 0, 0);
    step(3);
    apply_stimulus(6'd0, 1, 0, 0);
    step(10);
    check_output("glitch_active", int'(bus.alarm_active), 0);

    apply_stimulus(6'b000100, 1, 0, 0);
    step(6);
    check_output("trip_early", int'(bus.alarm_active), 0);
    step(1);
    check_output("trip_active", int'(bus.alarm_active), 1);
    check_output("trip_led",    int'(bus.led_enable),   6'b000100);
    check_output("trip_first",  int'(bus.first_zone),   2);
    check_output("trip_count",  int'(bus.alarm_count),  1);

    apply_stimulus(6'b100100, 1, 0, 0);
    step(7);
    check_output("accum_led", int'(bus.led_enable), 6'b100100);

    apply_stimulus(6'd0, 1, 0, 0);
    step(8);
    check_output("latched_led", int'(bus.led_enable), 6'b100100);
    apply_stimulus(6'd0, 1, 1, 0);
    step(7);
    check_output("ack_active", int'(bus.alarm_active), 0);
    check_output("ack_led",    int'(bus.led_enable),   0);
    check_output("ack_first",  int'(bus.first_zone),   7);

    // Re-trip with ack still held: no second ack event may clear it.
    apply_stimulus(6'b000010, 1, 1, 0);
    step(17);
    check_output("held_active", int'(bus.alarm_active), 1);
    check_output("held_led",    int'(bus.led_enable),   6'b000010);
    check_output("held_first",  int'(bus.first_zone),   1);
    check_output("held_count",  int'(bus.alarm_count),  2);

    apply_stimulus(6'b000001, 1, 0, 0);
    step(8);
    check_output("or_led", int'(bus.led_enable), 6'b000011);
    apply_stimulus(6'b000001, 1, 1, 0);
    step(7);
    check_output("ack_live_led",    int'(bus.led_enable),   6'b000001);
    check_output("ack_live_active", int'(bus.alarm_active), 1);
    check_output("ack_live_first",  int'(bus.first_zone),   1);
    apply_stimulus(6'b000001, 1, 0, 0);
    step(8);

    apply_stimulus(6'b000001, 0, 1, 0);
    step(7);
    check_output("prio_active", int'(bus.alarm_active), 0);
    check_output("prio_led",    int'(bus.led_enable),   0);
    check_output("prio_first",  int'(bus.first_zone),   7);
    apply_stimulus(6'd0, 0, 0, 0);
    step(8);

    // Maintenance: a 7-cycle hold falls short, an 8-cycle hold enters.
    apply_stimulus(6'd0, 0, 0, 1);
    step(7);
    apply_stimulus(6'd0, 0, 0, 0);
    step(14);
    check_output("hold7_mtne", int'(bus.mtne_mode), 0);
    apply_stimulus(6'd0, 0, 0, 1);
    step(13);
    check_output("hold_pre_mtne", int'(bus.mtne_mode), 0);
    step(1);
    check_output("hold8_mtne", int'(bus.mtne_mode), 1);
    apply_stimulus(6'b001010, 1, 1, 1);
    step(7);
    check_output("mtne_led",    int'(bus.led_enable),   6'b001010);
    check_output("mtne_active", int'(bus.alarm_active), 0);
    apply_stimulus(6'b001010, 0, 0, 0);
    step(7);
    check_output("mtne_exit",     int'(bus.mtne_mode),  0);
    check_output("mtne_exit_led", int'(bus.led_enable), 0);
    apply_stimulus(6'd0, 0, 0, 0);
    step(8);

    apply_stimulus(6'd0, 1, 0, 0);
    step(8);
    apply_stimulus(6'b000001, 1, 0, 0);
    step(7);
    check_output("pre_rst_count", int'(bus.alarm_count), 3);
    reset = 1'b0;
    step(1);
    check_output("midrst_led",    int'(bus.led_enable),   0);
    check_output("midrst_active", int'(bus.alarm_active), 0);
    check_output("midrst_first",  int'(bus.first_zone),   7);
    check_output("midrst_count",  int'(bus.alarm_count),  0);
    reset = 1'b1;
    step(1);
    check_output("resume_active", int'(bus.alarm_active), 0);
    step(12);
    check_output("rearm_count", int'(bus.alarm_count), 1);

    // Toggle arm with zone 0 held high to drive the entry count past saturation.
    for (int n = 0; n < 300; n++) begin
      apply_stimulus(6'b000001, 0, 0, 0);
      step(8);
      apply_stimulus(6'b000001, 1, 0, 0);
      step(8);
    end
    check_output("sat_count",  int'(bus.alarm_count),  255);
    check_output("sat_active", int'(bus.alarm_active), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alarm_zone_controller.md
ALARM_ZONE_CONTROLLER -- requirements
Module: alarm_zone_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable samples needed to accept an input change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter MTNE_HOLD, default 100000000, the number of cycles mtne_key must be held to enter maintenance (2 s at 50 MHz).
REQ-003 clock  input  1  system clock; the only clock; all state is updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 sensor_in  input  6  raw asynchronous zone sensors; 1 means tripped.
REQ-006 arm_sw  input  1  raw asynchronous arm switch; 1 means armed.
REQ-007 ack_btn  input  1  raw asynchronous acknowledge push-button; 1 means pressed.
REQ-008 mtne_key  input  1  raw asynchronous maintenance key switch.
REQ-009 led_enable  output  6  per-zone LED enable, feeding the LED sequencer.
REQ-010 mtne_mode  output  1  maintenance indication, feeding the LED sequencer.
REQ-011 alarm_active  output  1  high while the FSM is in ALARM.
REQ-012 first_zone  output  3  index of the lowest tripped zone at ALARM entry; 3'd7 means none.
REQ-013 alarm_count  output  8  number of ALARM entries since reset; saturates at 255.

Function
REQ-014 Input conditioning: each of the 9 raw inputs SHALL pass through a 2-flop synchronizer and then an independent debouncer.
REQ-015 Debounce: the debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any intervening agreeing sample restarts the count.
REQ-016 Debounce latency: a clean raw step SHALL appear on the debounced level at clock edge 2+DEBOUNCE_CYCLES after the change, and on the registered outputs one edge later.
REQ-017 Acknowledge: an ack event SHALL be a single-cycle pulse on the 0->1 transition of debounced ack_btn; holding the button SHALL NOT repeat the event.
REQ-018 FSM: the FSM SHALL have exactly four states: DISARMED, ARMED, ALARM, MAINT.
REQ-019 DISARMED: outputs SHALL be zone latch = 0, led_enable = 0, mtne_mode = 0; transitions SHALL be arm_sw=1 -> ARMED, or mtne_key held -> MAINT.
REQ-020 Maintenance entry: the transition to MAINT SHALL require the hold counter to reach MTNE_HOLD.
REQ-021 Hold counter: it SHALL increment only while in DISARMED with debounced mtne_key=1 and arm_sw=0, and clear otherwise.
REQ-022 Arm/maintenance priority: if arm_sw=1 in the same cycle the hold count completes, the FSM SHALL go to ARMED.
REQ-023 ARMED: led_enable SHALL be 0.
REQ-024 ARMED exit on trip: any debounced sensor = 1 SHALL set zone latch = sensors, set first_zone = lowest set index, increment alarm_count (saturating) and go to ALARM.
REQ-025 ARMED disarm: arm_sw=0 SHALL go to DISARMED, and SHALL take priority over a simultaneous trip.
REQ-026 ALARM: led_enable SHALL equal the zone latch; the latch SHALL OR in newly tripped sensors each cycle; first_zone SHALL hold.
REQ-027 ALARM ack: an ack event SHALL load latch = current debounced sensors; if the result is 0 the FSM SHALL go to ARMED with first_zone = 7, otherwise it SHALL stay in ALARM.
REQ-028 ALARM disarm: arm_sw=0 SHALL go to DISARMED, clear the latch, set first_zone = 7, and take priority over a simultaneous ack.
REQ-029 MAINT: mtne_mode SHALL be 1 and led_enable SHALL equal the live debounced sensors; arm_sw and ack_btn SHALL be ignored; debounced mtne_key=0 SHALL go to DISARMED.
REQ-030 Register timing: all outputs SHALL be registered and SHALL reflect state and latch contents one edge after the deciding condition.
REQ-031 alarm_active SHALL be 1 exactly while the state is ALARM.

Reset
REQ-032 reset=0 at a rising edge SHALL force: state DISARMED, led_enable=0, mtne_mode=0, alarm_active=0, first_zone=7, alarm_count=0.
REQ-033 The same reset SHALL clear the hold counter and all debounce counters, and set all synchronizer and debounced levels to 0.
REQ-034 Reset SHALL override every other condition, including mid-ALARM and mid-MAINT operation; the block SHALL resume from DISARMED on the first edge with reset=1.

Verification (DEBOUNCE_CYCLES=4, MTNE_HOLD=8)
REQ-035 Debounce test: sensor_in[2] pulses high for 3 cycles while ARMED -> no state change; held high for 4+ cycles -> ALARM, led_enable=6'b000100, first_zone=2, alarm_count=1 at edge 7 after the rise.
REQ-036 Accumulate/ack test: in ALARM, trip zone 5 -> led_enable=6'b100100; release all sensors, then ack -> ARMED, led_enable=0, first_zone=7; ack again while held -> no second event.
REQ-037 Ack with active sensor test: in ALARM with sensor 0 still high, ack -> latch=6'b000001, state remains ALARM.
REQ-038 Maintenance test: in DISARMED, hold mtne_key for 7 debounced cycles -> stays DISARMED; hold for 8 -> mtne_mode=1 and led_enable tracks sensors; release key -> DISARMED, mtne_mode=0.
REQ-039 Priority test: in ALARM, arm_sw falls in the same debounced cycle as an ack -> DISARMED with latch=0; alarm_count saturates at 255 after 256 alarm entries.
REQ-040 Reset test: assert reset mid-ALARM for 1 cycle -> all outputs at reset values on that edge; deassert -> DISARMED.
